// File: rtl/ghost_move_commit_pkg.sv
// Shared geometry, tile grid and direction encodings for ghost movement.
// Imported by the position owner and the tile index helper.
package ghost_move_commit_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int TILE_SIZE    = 20;
  localparam int TILE_ROW_NUM = HEIGHT / TILE_SIZE;
  localparam int TILE_COL_NUM = WIDTH / TILE_SIZE;
  localparam int NTILES       = TILE_ROW_NUM * TILE_COL_NUM;

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int COLW = $clog2(TILE_COL_NUM);
  localparam int ROWW = $clog2(TILE_ROW_NUM);
  localparam int IDXW = $clog2(NTILES);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

endpackage

// File: rtl/ghost_move_commit_tile.sv
// Pixel to tile mapping: column, row, alignment and flat wall-bit index.
// Col/row are truncated; callers must bound-check the pixel first.
module tile_index
  import ghost_move_commit_pkg::*;
(
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  output logic [COLW-1:0] col,
  output logic [ROWW-1:0] row,
  output logic            aligned,
  output logic [IDXW-1:0] index
);

  logic [XW-1:0] rx;
  logic [YW-1:0] ry;

  assign col = COLW'(x / XW'(TILE_SIZE));
  assign row = ROWW'(y / YW'(TILE_SIZE));
  assign rx  = x % XW'(TILE_SIZE);
  assign ry  = y % YW'(TILE_SIZE);

  assign aligned = (rx == '0) && (ry == '0);

  assign index = IDXW'(row) * IDXW'(TILE_COL_NUM)
               + IDXW'(col);

endmodule

// File: rtl/ghost_move_commit.sv
// Ghost position owner: rate-divided sample of the controller proposal,
// legality check against bounds/grid/walls, then commit or reject.
module ghost_move_commit
  import ghost_move_commit_pkg::*;
#(
  parameter int         TICK_DIV = 4,
  parameter int         INIT_X   = 600,
  parameter int         INIT_Y   = 320,
  parameter logic [1:0] INIT_DIR = DIR_DOWN,
  parameter int         TILE     = TILE_SIZE,
  parameter int         BOUND_X1 = 620,
  parameter int         BOUND_Y1 = 460
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              enable,
  input  logic [XW-1:0]     prop_x,
  input  logic [YW-1:0]     prop_y,
  input  logic [1:0]        prop_dir,
  input  logic [NTILES-1:0] tilemap_walls,
  input  logic [XW-1:0]     pac_x,
  input  logic [YW-1:0]     pac_y,
  output logic [XW-1:0]     cur_x,
  output logic [YW-1:0]     cur_y,
  output logic [1:0]        cur_dir,
  output logic              move_done,
  output logic              blocked,
  output logic              caught,
  output logic              busy
);

  localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [DIVW-1:0] div, div_n;
  logic [XW-1:0]   lx;
  logic [YW-1:0]   ly;
  logic [1:0]      ldir;
  logic            commit, reject, ok;

  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;
  logic            aligned;
  logic [IDXW-1:0] index;

  tile_index u_tile (
    .x       (lx),
    .y       (ly),
    .col     (col),
    .row     (row),
    .aligned (aligned),
    .index   (index)
  );

  // Bounds test first: it also guards the truncated col/row below.
  always_comb begin
    ok = 1'b1;
    if (lx > XW'(BOUND_X1) || ly > YW'(BOUND_Y1))
      ok = 1'b0;
    if (!aligned)
      ok = 1'b0;
    if (32'(row) >= TILE_ROW_NUM || 32'(col) >= TILE_COL_NUM)
      ok = 1'b0;
    else if (tilemap_walls[index])
      ok = 1'b0;
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    commit  = 1'b0;
    reject  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && enable) begin
          if (div == DIV_LAST) begin
            div_n   = '0;
            state_n = SAMPLE;
          end else begin
            div_n = div + 1'b1;
          end
        end
      end
      SAMPLE: state_n = CHECK;
      CHECK: begin
        state_n = IDLE;
        commit  = ok;
        reject  = !ok;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div       <= '0;
      lx        <= XW'(INIT_X);
      ly        <= YW'(INIT_Y);
      ldir      <= INIT_DIR;
      cur_x     <= XW'(INIT_X);
      cur_y     <= YW'(INIT_Y);
      cur_dir   <= INIT_DIR;
      move_done <= 1'b0;
      blocked   <= 1'b0;
      caught    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      busy      <= (state_n != IDLE);
      move_done <= commit;
      blocked   <= reject;
      caught    <= commit && (lx == pac_x) && (ly == pac_y);
      if (state == SAMPLE) begin
        lx   <= prop_x;
        ly   <= prop_y;
        ldir <= prop_dir;
      end
      if (commit) begin
        cur_x   <= lx;
        cur_y   <= ly;
        cur_dir <= ldir;
      end
    end
  end

endmodule

// File: tb/tb_ghost_move_commit.sv
// Randomized and directed bench for ghost_move_commit against an
// attempt-timeline reference model.
module tb_ghost_move_commit;

  localparam int TDIV = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tick = 1'b0;
  logic         enable = 1'b1;
  logic [9:0]   prop_x = 10'd600;
  logic [8:0]   prop_y = 9'd320;
  logic [1:0]   prop_dir = 2'd0;
  logic [767:0] walls = '0;
  logic [9:0]   pac_x = 10'd0;
  logic [8:0]   pac_y = 9'd0;
  logic [9:0]   cur_x;
  logic [8:0]   cur_y;
  logic [1:0]   cur_dir;
  logic         move_done, blocked, caught, busy;

  ghost_move_commit dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .enable        (enable),
    .prop_x        (prop_x),
    .prop_y        (prop_y),
    .prop_dir      (prop_dir),
    .tilemap_walls (walls),
    .pac_x         (pac_x),
    .pac_y         (pac_y),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .cur_dir       (cur_dir),
    .move_done     (move_done),
    .blocked       (blocked),
    .caught        (caught),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  // Reference model: each attempt is a timeline of edge numbers.
  int e = 0;
  int ticks = 0;
  int start_e = -10;
  int commit_e = -10;
  int lx, ly, ldir;
  int mx = 600, my = 320, mdir = 1;
  bit emd, eblk, ecau, ebusy;

  function automatic bit legal(int x, int y);
    if (x > 620 || y > 460) return 1'b0;
    if ((x % 20) != 0 || (y % 20) != 0) return 1'b0;
    if (y / 20 >= 24 || x / 20 >= 32) return 1'b0;
    return !walls[(y / 20) * 32 + x / 20];
  endfunction

  always @(posedge clk) begin
    e++;
    if (!reset) begin
      ticks = 0; start_e = -10; commit_e = -10;
      mx = 600; my = 320; mdir = 1;
      emd = 0; eblk = 0; ecau = 0; ebusy = 0;
    end else begin
      emd = 0; eblk = 0; ecau = 0;
      if (e == commit_e) begin
        if (legal(lx, ly)) begin
          mx = lx; my = ly; mdir = ldir; emd = 1;
          ecau = (lx == int'(pac_x)) && (ly == int'(pac_y));
        end else begin
          eblk = 1;
        end
      end
      if (e == commit_e - 1) begin
        lx = prop_x; ly = prop_y; ldir = prop_dir;
      end
      if (!(e > start_e && e <= commit_e) && tick && enable) begin
        ticks++;
        if (ticks == TDIV) begin
          ticks = 0; start_e = e; commit_e = e + 2;
        end
      end
      ebusy = (e >= start_e) && (e < commit_e);
    end
  end

  initial begin
    emd = 0; eblk = 0; ecau = 0; ebusy = 0;
  end

  task automatic step(input bit t, input bit en);
    @(negedge clk);
    chk("cur_x", cur_x, mx);
    chk("cur_y", cur_y, my);
    chk("cur_dir", cur_dir, mdir);
    chk("move_done", move_done, emd);
    chk("blocked", blocked, eblk);
    chk("caught", caught, ecau);
    chk("busy", busy, ebusy);
    tick = t;
    enable = en;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(0, 1);
    step(0, 1);
    reset = 1'b1;
  endtask

  task automatic attempt(input int px, input int py);
    prop_x = 10'(px);
    prop_y = 9'(py);
    repeat (TDIV) step(1, 1);
    repeat (4) step(0, 1);
  endtask

  int n_md = 0;
  int n_blk = 0;

  always @(negedge clk) begin
    if (reset && move_done) n_md++;
    if (reset && blocked) n_blk++;
  end

  initial begin
    do_reset();
    step(0, 1);

    // legal move down one tile
    prop_dir = 2'd1;
    attempt(600, 340);
    chk("legal_pos", cur_y, 340);

    // wall directly below the reset position
    do_reset();
    walls[17 * 32 + 30] = 1'b1;
    attempt(600, 340);
    chk("wall_hold", cur_y, 320);
    walls = '0;

    // wrapped X and misaligned X
    attempt(0 - 20, 320);
    attempt(610, 320);
    chk("oob_hold", cur_x, 600);

    // catch
    pac_x = 10'd600;
    pac_y = 9'd340;
    attempt(600, 340);
    pac_x = 10'd0;
    pac_y = 9'd0;

    // tick gating while disabled: 3 + (5 gated) + 1
    do_reset();
    prop_x = 10'd580;
    prop_y = 9'd320;
    prop_dir = 2'd2;
    repeat (3) step(1, 1);
    repeat (5) step(1, 0);
    step(1, 1);
    repeat (4) step(0, 1);
    chk("gate_pos", cur_x, 580);

    // reset during CHECK
    prop_x = 10'd580;
    prop_y = 9'd340;
    repeat (TDIV) step(1, 1);
    step(0, 1);
    step(0, 1);
    reset = 1'b0;
    step(0, 1);
    reset = 1'b1;
    repeat (3) step(0, 1);
    chk("rst_mid_x", cur_x, 600);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0)
        for (int i = 0; i < 768; i++)
          walls[i] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        prop_x = 10'($urandom);
        prop_y = 9'($urandom);
      end else begin
        prop_x = 10'(mx + 20 * ($urandom_range(0, 2) - 1));
        prop_y = 9'(my + 20 * ($urandom_range(0, 2) - 1));
      end
      prop_dir = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        pac_x = prop_x;
        pac_y = prop_y;
      end else begin
        pac_x = 10'(20 * $urandom_range(0, 31));
        pac_y = 9'(20 * $urandom_range(0, 23));
      end
      if ($urandom_range(0, 599) == 0) reset = 1'b0;
      else reset = 1'b1;
    end
    reset = 1'b1;
    repeat (4) step(0, 1);
    chk("saw_moves", int'(n_md > 10), 1);
    chk("saw_blocks", int'(n_blk > 10), 1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/ghost_move_commit.md
Name: ghost_move_commit

Overview:
- Position owner and move arbiter for one ghost.
- Holds the ghost's committed position and drives it to the ghost direction controller as its x/y inputs.
- At a programmable move rate, samples the controller's proposed next_x/next_y/direction, checks the proposal against the screen bounds, the tile grid and tilemap_walls, then either commits it or rejects it.
- Flags a catch when the committed position equals Pac-Man's position.

Parameters:
- TICK_DIV, 4, number of accepted tick pulses per move attempt (ghost speed); minimum 1.
- INIT_X, 600, reset X position in pixels.
- INIT_Y, 320, reset Y position in pixels.
- INIT_DIR, `dir_down, reset committed direction.
- TILE, 20, tile size in pixels.
- BOUND_X1, 620, largest legal X.
- BOUND_Y1, 460, largest legal Y.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle move-timer pulse
- enable  input  1  high = moves allowed; low = frozen
- prop_x  input  $clog2(`WIDTH)  proposed X (controller next_x)
- prop_y  input  $clog2(`HEIGHT)  proposed Y (controller next_y)
- prop_dir  input  2  proposed direction (controller ghost_direction)
- tilemap_walls  input  `tile_row_num*`tile_col_num  wall bitmap; bit index = row*`tile_col_num + col
- pac_x  input  $clog2(`WIDTH)  Pac-Man X
- pac_y  input  $clog2(`HEIGHT)  Pac-Man Y
- cur_x  output  $clog2(`WIDTH)  committed X (to controller x)
- cur_y  output  $clog2(`HEIGHT)  committed Y (to controller y)
- cur_dir  output  2  committed direction
- move_done  output  1  one-cycle pulse: proposal committed
- blocked  output  1  one-cycle pulse: proposal rejected
- caught  output  1  one-cycle pulse: committed position == (pac_x, pac_y)
- busy  output  1  high while an attempt is in flight

Behaviour:
- Reset values (asynchronous): cur_x=INIT_X, cur_y=INIT_Y, cur_dir=INIT_DIR, move_done=blocked=caught=busy=0, divider=0, state=IDLE.
- IDLE
  - When tick&&enable: if divider==TICK_DIV-1, then divider<=0, state<=SAMPLE, busy<=1; otherwise divider++.
  - When enable=0: divider holds its value and is not cleared.
- SAMPLE (1 cycle)
  - Latch prop_x, prop_y, prop_dir.
  - Compute col=prop_x/TILE and row=prop_y/TILE, plus the remainders.
  - Go to CHECK.
- CHECK (1 cycle): reject if any of the following holds:
  - latched x>BOUND_X1 or y>BOUND_Y1 (this also catches unsigned underflow from 0-speed);
  - either remainder is nonzero;
  - row>=`tile_row_num or col>=`tile_col_num;
  - tilemap_walls[row*`tile_col_num+col]==1.
- CHECK outcome:
  - Accept: cur_x/cur_y/cur_dir <= latched values, move_done<=1, caught<=(latched x==pac_x && latched y==pac_y).
  - Reject: position and direction held, blocked<=1.
  - Either way: busy<=0, state<=IDLE.
- Latency: the edge that sees the terminal tick is E0. SAMPLE runs at E1. At E2, cur_* updates and move_done/blocked/caught rise. They clear at E3.
- Pulses: move_done, blocked and caught are single-cycle and mutually exclusive, except that caught is only ever asserted together with move_done. move_done and blocked are never both high.
- Ticks arriving while busy=1 are ignored and not counted.
- enable falling mid-attempt: the in-flight attempt completes normally.
- Proposals equal to the current position (controller idle) go through the same checks; if accepted, the commit still pulses move_done.
- Reset asserted mid-attempt: all state returns to reset values immediately and no pulse is emitted.
- Division by TILE uses the constant divisor; inputs are bounded by `WIDTH/`HEIGHT, so the quotient widths are $clog2(`tile_col_num) and $clog2(`tile_row_num).

Decomposition:
- Shared define file (existing define.v): `WIDTH, `HEIGHT, `tile_row_num, `tile_col_num, `dir_up/`dir_down/`dir_left/`dir_right, plus a new `tile_size.
- State encodings (IDLE/SAMPLE/CHECK) are localparams inside the module.
- One combinational sub-module, tile_index: it takes a pixel x,y and returns col, row, an aligned flag and a flat bit index. Pac-Man and other ghosts reuse it.

Test Plan:
- Reset sequence: release reset with TICK_DIV=4 -> cur=(600,320), cur_dir=`dir_down, all pulses 0, busy 0.
- Legal move: prop=(600,340), free tile, 4 ticks -> at E2 after the 4th tick, cur=(600,340), move_done for 1 cycle, busy high for exactly 2 cycles.
- Wall hit: set bit 17*`tile_col_num+30, prop=(600,340) -> blocked pulse, cur stays (600,320), no move_done.
- Out of bounds and misaligned: prop_x=0-20 (wrapped value) -> blocked; prop=(610,320) -> blocked.
- Catch: pac=(600,340), legal prop=(600,340) -> move_done and caught in the same cycle.
- Gating and reset mid-flight: (a) 3 ticks, enable=0, 5 ticks, enable=1, 1 tick -> a move attempt starts; (b) reset pulsed during CHECK -> cur=(600,320) and no pulses.
